// File: rtl/adc_ram_wr_sched_pkg.sv
// Shared types and constants for the ADC-to-RAM write scheduler.
`timescale 1ns/1ps
`default_nettype none

package adc_ram_wr_sched_pkg;

  localparam int WORD_W         = 256;
  localparam int BYTES_PER_WORD = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_CMD       = 3'd2,
    S_DATA      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adc_ram_wr_sched_wr_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the memory write channel.
`timescale 1ns/1ps
`default_nettype none

module wr_skid_buf
  import adc_ram_wr_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] head_word;
  logic [WORD_W-1:0] tail_word;
  logic [1:0]        cnt;
  logic              push;
  logic              pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = head_word;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_word <= '0;
      tail_word <= '0;
      cnt       <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head_word <= in_data;
          else             tail_word <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head_word <= tail_word;
          cnt       <= cnt - 2'd1;
        end
        // Simultaneous push/pop only happens with one entry held
        2'b11:   head_word <= in_data;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_ram_wr_sched.sv
// Moves ADC frames from the FIFO into ping/pong memory buffers as bursts of 256-bit words.
`timescale 1ns/1ps
`default_nettype none

module adc_ram_wr_sched
  import adc_ram_wr_sched_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 4096,
  parameter int ADDR_W      = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] buf_base0,
  input  logic [ADDR_W-1:0] buf_base1,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_rd_data,
  input  logic              fifo_valid,
  input  logic [6:0]        fifo_rd_data_count,
  input  logic              fifo_full,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [5:0]        mem_cmd_len,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [WORD_W-1:0] mem_wr_data,
  output logic              mem_wr_last,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_buf,
  output logic              err_overflow
);

  localparam int REM_RAW = $clog2(FRAME_WORDS + 1);
  localparam int REM_W   = (REM_RAW < 8) ? 8 : REM_RAW;

  state_t            state;
  state_t            state_nxt;
  logic [REM_W-1:0]  remaining;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        len;
  logic [6:0]        blen;
  logic [6:0]        blen_calc;
  logic [6:0]        rd_issued;
  logic [6:0]        retired;
  logic              inflight;
  logic              buf_idx;
  logic              sb_in_ready;
  logic [1:0]        sb_count;
  logic              capture;
  logic              retire;
  logic              last_retire;
  logic [2:0]        occupancy;

  assign blen      = {1'b0, len} + 7'd1;
  assign blen_calc = (remaining >= REM_W'(BURST_LEN)) ? 7'(BURST_LEN) : remaining[6:0];

  assign capture     = fifo_valid && (state == S_DATA);
  assign retire      = mem_wr_valid && mem_wr_ready;
  assign mem_wr_last = mem_wr_valid && (retired == {1'b0, len});
  assign last_retire = retire && (retired == {1'b0, len});

  // Count a word leaving this cycle as free so reads can stream at one per cycle
  assign occupancy = {1'b0, sb_count} + {2'b00, inflight} - {2'b00, retire};

  assign mem_cmd_addr = addr;
  assign mem_cmd_len  = len;

  always_comb begin
    state_nxt     = state;
    mem_cmd_valid = 1'b0;
    frame_done    = 1'b0;
    busy          = (state != S_IDLE);
    fifo_rd_en    = 1'b0;
    case (state)
      S_IDLE:      if (start) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (fifo_rd_data_count >= blen_calc) state_nxt = S_CMD;
      S_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        fifo_rd_en = (occupancy < 3'd2) && (rd_issued < blen) && sb_in_ready;
        if (last_retire)
          state_nxt = (remaining == REM_W'(blen)) ? S_DONE : S_WAIT_DATA;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      addr         <= '0;
      len          <= '0;
      rd_issued    <= '0;
      retired      <= '0;
      inflight     <= 1'b0;
      buf_idx      <= 1'b0;
      frame_buf    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (fifo_rd_en) rd_issued <= rd_issued + 7'd1;
      if (retire)     retired   <= retired + 7'd1;
      if (busy && fifo_full) err_overflow <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          remaining    <= REM_W'(FRAME_WORDS);
          addr         <= buf_idx ? buf_base1 : buf_base0;
          err_overflow <= 1'b0;
        end
        S_WAIT_DATA: begin
          len       <= 6'(blen_calc - 7'd1);
          rd_issued <= '0;
          retired   <= '0;
        end
        S_DATA: if (last_retire) begin
          addr      <= addr + ADDR_W'(blen) * ADDR_W'(BYTES_PER_WORD);
          remaining <= remaining - REM_W'(blen);
        end
        S_DONE: begin
          frame_buf <= buf_idx;
          buf_idx   <= ~buf_idx;
        end
        default: ;
      endcase
    end
  end

  wr_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (capture),
    .in_ready  (sb_in_ready),
    .in_data   (fifo_rd_data),
    .out_valid (mem_wr_valid),
    .out_ready (mem_wr_ready),
    .out_data  (mem_wr_data),
    .count     (sb_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_adc_ram_wr_sched.sv
// Scoreboard bench for adc_ram_wr_sched: 20-word frames in 8-word bursts.
`timescale 1ns/1ps
`default_nettype none

module tb_adc_ram_wr_sched;

  localparam int AW = 29;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] buf_base0 = 29'h0100_0000;
  logic [AW-1:0] buf_base1 = 29'h1FFF_FF00;
  logic          fifo_rd_en;
  logic [255:0]  fifo_rd_data = '0;
  logic          fifo_valid = 1'b0;
  logic [6:0]    fifo_cnt = '0;
  logic          fifo_full = 1'b0;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready = 1'b0;
  logic [AW-1:0] mem_cmd_addr;
  logic [5:0]    mem_cmd_len;
  logic          mem_wr_valid;
  logic          mem_wr_ready = 1'b0;
  logic [255:0]  mem_wr_data;
  logic          mem_wr_last;
  logic          busy;
  logic          frame_done;
  logic          frame_buf;
  logic          err_overflow;

  adc_ram_wr_sched #(.BURST_LEN(8), .FRAME_WORDS(20), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .buf_base0(buf_base0), .buf_base1(buf_base1),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_valid(fifo_valid),
    .fifo_rd_data_count(fifo_cnt), .fifo_full(fifo_full),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last),
    .busy(busy), .frame_done(frame_done), .frame_buf(frame_buf),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [5:0]    len;
  } cmd_t;

  logic [255:0] fifo_q[$];
  logic [255:0] exp_data[$];
  cmd_t         exp_cmd[$];
  int           burst_len_q[$];

  // FIFO model: data and valid one cycle after the read strobe
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      chk("fifo_underflow", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    end
    fifo_valid <= fifo_rd_en;
    fifo_cnt   <= 7'(fifo_q.size());
  end

  int cmd_mode = 0;
  int wr_mode  = 0;
  int cmd_wait = 0;

  always @(posedge clk) begin
    #2;
    if (cmd_mode == 0) mem_cmd_ready = 1'b1;
    else if (mem_cmd_valid) begin
      mem_cmd_ready = (cmd_wait >= 5);
      cmd_wait++;
    end else begin
      mem_cmd_ready = 1'b0;
      cmd_wait = 0;
    end
    if (wr_mode == 0) mem_wr_ready = 1'b1;
    else              mem_wr_ready = ~mem_wr_ready;
  end

  int   beats = 0;
  int   idx = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   burst_start = 0;
  bit   fast = 1'b1;
  cmd_t c;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mem_cmd_valid && mem_cmd_ready) begin
        chk("cmd_expected", exp_cmd.size() > 0, 1);
        if (exp_cmd.size() > 0) begin
          c = exp_cmd.pop_front();
          chk("cmd_addr", mem_cmd_addr, c.addr);
          chk("cmd_len", mem_cmd_len, c.len);
          burst_len_q.push_back(int'(c.len));
        end
      end
      if (mem_wr_valid && mem_wr_ready) begin
        chk("wr_expected", (exp_data.size() > 0) && (burst_len_q.size() > 0), 1);
        if (exp_data.size() > 0 && burst_len_q.size() > 0) begin
          chk("wr_data", mem_wr_data, exp_data.pop_front());
          if (idx == 0) burst_start = cyc;
          chk("wr_last", mem_wr_last, idx == burst_len_q[0]);
          beats++;
          if (idx == burst_len_q[0]) begin
            if (fast) chk("burst_span", cyc - burst_start + 1, idx + 1);
            void'(burst_len_q.pop_front());
            idx = 0;
          end else idx++;
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input int n);
    logic [255:0] w;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom();
      fifo_q.push_back(w);
      exp_data.push_back(w);
    end
  endtask

  task automatic expect_frame(input logic [AW-1:0] base);
    cmd_t e;
    for (int k = 0; k < 3; k++) begin
      e.addr = base + AW'(k * 256);
      e.len  = (k < 2) ? 6'd7 : 6'd3;
      exp_cmd.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!frame_done && n < limit) begin
      tick(1);
      n++;
    end
    chk("done_timeout", frame_done, 1);
  endtask

  task automatic wait_beats(input int target, input int limit);
    int n = 0;
    while (beats < target && n < limit) begin
      tick(1);
      n++;
    end
    chk("beat_timeout", beats >= target, 1);
  endtask

  task automatic chk_idle_outputs();
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    chk("rst_cmd_addr", mem_cmd_addr, 0);
    chk("rst_cmd_len", mem_cmd_len, 0);
    chk("rst_wr_valid", mem_wr_valid, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_wr_last", mem_wr_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_buf", frame_buf, 0);
    chk("rst_err_overflow", err_overflow, 0);
  endtask

  int beats_mark;

  initial begin
    rst_n = 1'b0;
    tick(3);
    chk_idle_outputs();
    rst_n = 1'b1;
    tick(2);

    // Frame A: buffer 0, full speed, data arrives after start
    expect_frame(buf_base0);
    pulse_start();
    tick(10);
    chk("wait_no_cmd", mem_cmd_valid, 0);
    chk("busy_waiting", busy, 1);
    fill(20);
    wait_beats(10, 300);
    pulse_start();
    wait_done(300);
    tick(1);
    chk("a_frame_buf", frame_buf, 0);
    chk("a_busy_low", busy, 0);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_beats", beats, 20);
    tick(15);
    chk("a_no_extra_cmd", exp_cmd.size(), 0);

    // Frame B: buffer 1 with address wrap, stalled handshakes, overflow flag
    cmd_mode = 1;
    wr_mode  = 1;
    fast     = 1'b0;
    expect_frame(buf_base1);
    fill(20);
    pulse_start();
    wait_beats(25, 500);
    fifo_full = 1'b1;
    tick(1);
    fifo_full = 1'b0;
    chk("b_overflow_set", err_overflow, 1);
    wait_done(1000);
    tick(1);
    chk("b_frame_buf", frame_buf, 1);
    chk("b_overflow_hold", err_overflow, 1);
    chk("b_done_cnt", done_cnt, 2);
    chk("b_beats", beats, 40);

    // Frame C: restart clears overflow; reset lands mid-burst
    cmd_mode = 0;
    wr_mode  = 0;
    fast     = 1'b1;
    tick(2);
    expect_frame(buf_base0);
    pulse_start();
    chk("c_overflow_clr", err_overflow, 0);
    fill(20);
    wait_beats(43, 300);
    rst_n = 1'b0;
    tick(1);
    chk_idle_outputs();
    fifo_q.delete();
    exp_data.delete();
    exp_cmd.delete();
    burst_len_q.delete();
    idx = 0;
    rst_n = 1'b1;
    tick(3);

    // Frame D: buffer index restarted at 0
    beats_mark = beats;
    expect_frame(buf_base0);
    fill(20);
    pulse_start();
    wait_done(300);
    tick(1);
    chk("d_frame_buf", frame_buf, 0);
    chk("d_beats", beats - beats_mark, 20);
    chk("d_done_cnt", done_cnt, 3);
    chk("d_data_drained", exp_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_ram_wr_sched.md
ADC_RAM_WR_SCHED -- requirements
Module: adc_ram_wr_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8: max 256-bit words per memory burst (1..64).
REQ-002 SHALL have parameter FRAME_WORDS, default 4096: 256-bit words per frame (>=1; need not be a multiple of BURST_LEN).
REQ-003 SHALL have parameter ADDR_W, default 29: memory byte-address width.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports:
 clk  in  1  sole clock; also drives the ADC-to-RAM FIFO read side
 rst_n  in  1  synchronous active-low reset
 start  in  1  pulse: arm capture of one frame
 buf_base0 / buf_base1  in  ADDR_W  byte base address of ping / pong frame buffer
 fifo_rd_en  out  1  read strobe to ADC-to-RAM FIFO
 fifo_rd_data  in  256  FIFO data, valid one cycle after fifo_rd_en
 fifo_valid  in  1  FIFO data-valid
 fifo_rd_data_count  in  7  FIFO occupancy in 256-bit words
 fifo_full  in  1  FIFO full flag
 mem_cmd_valid  out  1  write command request
 mem_cmd_ready  in  1  command accept
 mem_cmd_addr  out  ADDR_W  burst start byte address
 mem_cmd_len  out  6  burst length minus 1
 mem_wr_valid  out  1  write data valid
 mem_wr_ready  in  1  write data accept
 mem_wr_data  out  256  write data
 mem_wr_last  out  1  final word of burst
 busy  out  1  frame in progress
 frame_done  out  1  one-cycle pulse at frame completion
 frame_buf  out  1  buffer index of last completed frame
 err_overflow  out  1  sticky: fifo_full seen while busy

Function
REQ-006 SHALL implement FSM IDLE, WAIT_DATA, CMD, DATA, DONE.
REQ-007 IDLE: start -> WAIT_DATA; remaining := FRAME_WORDS; addr := base of current buffer; busy := 1; err_overflow cleared.
REQ-008 start while busy SHALL be ignored.
REQ-009 WAIT_DATA: blen := min(BURST_LEN, remaining); -> CMD when fifo_rd_data_count >= blen.
REQ-010 CMD: mem_cmd_valid held high with stable addr/len until mem_cmd_ready sampled high; then -> DATA. Ready high in the first valid cycle completes the handshake in that cycle.
REQ-011 DATA: exactly blen words transferred; 2-entry output buffer; fifo_rd_en high only when (buffered + in-flight reads) < 2 and reads issued < blen.
REQ-012 Word captured into buffer on fifo_valid; mem_wr_valid high whenever buffer non-empty; word retired on mem_wr_valid & mem_wr_ready.
REQ-013 Sustained throughput 1 word/cycle when mem_wr_ready stays high; mem_wr_data/mem_wr_valid/mem_wr_last stable while stalled.
REQ-014 mem_wr_last SHALL be high on the blen-th word only.
REQ-015 On last word retired: addr += blen*32; remaining -= blen; -> WAIT_DATA if remaining > 0, else DONE.
REQ-016 DONE (one cycle): frame_done = 1; frame_buf := current buffer; buffer index toggles; busy := 0; -> IDLE.
REQ-017 start in DONE cycle SHALL be ignored; next frame needs start in IDLE.
REQ-018 fifo_full high while busy SHALL set err_overflow; it holds until next accepted start or reset; no effect on sequencing.
REQ-019 FIFO read SHALL never occur outside DATA; FIFO never read when occupancy insufficient.
REQ-020 Address arithmetic modulo 2^ADDR_W; no base alignment check.

Reset
REQ-021 On rst_n low at a clk edge: state IDLE; all outputs 0 (fifo_rd_en, mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_wr_valid, mem_wr_data, mem_wr_last, busy, frame_done, frame_buf, err_overflow); buffer index 0; output buffer emptied.
REQ-022 Reset mid-burst SHALL abandon the burst with no further handshakes; FIFO contents untouched.

Structure
REQ-023 Shared package SHALL hold FSM state enum, 256-bit word width, and bytes-per-word (32) constant.
REQ-024 The 2-entry output buffer SHALL be sub-module wr_skid_buf (256-bit, valid/ready both sides).

Verification
REQ-025 FRAME_WORDS=16, BURST_LEN=8, FIFO prefilled, ready always high -> 2 bursts at buf_base0, buf_base0+256, len=7, 16 contiguous data cycles, frame_done once, frame_buf=0.
REQ-026 FRAME_WORDS=20, BURST_LEN=8 -> bursts len 7,7,3 at +0,+256,+512; mem_wr_last on words 8,16,20.
REQ-027 mem_cmd_ready delayed 5 cycles, mem_wr_ready toggling 1/0 -> addr/len/data stable while stalled, no word lost or duplicated, data order matches FIFO order.
REQ-028 Two frames back-to-back -> second frame uses buf_base1, frame_buf=1; start during busy ignored.
REQ-029 rst_n low during 4th data word -> next cycle all outputs 0, state IDLE; fresh start writes from buf_base0.
REQ-030 fifo_full pulsed mid-frame -> err_overflow=1 until next start, transfer count unchanged.
